uart_byte_transceiver: RTL and testbench
========================================

# uart_byte_transceiver

Byte-level 8N1 UART transmitter and receiver that sits between the word/byte encoder-decoder and the physical `tx`/`rx` pins. The TX side serialises one byte per active-low start request and reports readiness. The RX side deserialises incoming frames and delivers each byte with a one-cycle strobe. The RX side also flags the start of every frame so the memory interface can leave idle before data arrives.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line rate in baud.
- CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (integer division, 434 at defaults): cycles per bit. Must be ≥ 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tx_byte_start_n  in  1  active-low transmit request, sampled on each rising clk edge.
- byte_for_tx  in  8  byte to send; latched when a request is accepted.
- tx  out  1  serial output; idles high.
- tx_byte_ready  out  1  high when the TX side is idle and can accept a request.
- rx  in  1  serial input; asynchronous to clk.
- byte_from_rx  out  8  last correctly received byte; holds until the next good frame.
- rx_byte_ready  out  1  one-cycle pulse when byte_from_rx is updated.
- new_rx_byte_indicate  out  1  one-cycle pulse on a validated start bit.
- rx_frame_err  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- TX FSM states: TX_IDLE → TX_START → TX_DATA → TX_STOP → TX_IDLE.
  - TX_IDLE: tx = 1, tx_byte_ready = 1. A request is accepted when tx_byte_start_n = 0 in this state. On acceptance, byte_for_tx is latched into the shift register and the FSM moves to TX_START.
  - Each of TX_START, TX_DATA (per bit, 8 bits) and TX_STOP drives its bit for exactly CLKS_PER_BIT cycles. A 3-bit index selects the data bit.
  - tx_byte_start_n low while busy is ignored. The encoder holds start low for 2 cycles, and this must produce exactly one frame.
- RX path: rx passes through a 2-FF synchroniser (rx_s) before the FSM sees it.
- RX FSM states: RX_IDLE → RX_START → RX_DATA → RX_STOP, then RX_IDLE or RX_BREAK.
  - RX_IDLE: waits for rx_s = 0, then moves to RX_START.
  - RX_START: counts CLKS_PER_BIT/2 cycles and re-samples rx_s.
    - If rx_s = 0: start bit is valid. Pulse new_rx_byte_indicate and move to RX_DATA.
    - If rx_s = 1: glitch. Return to RX_IDLE with no pulse.
  - RX_DATA: samples rx_s every CLKS_PER_BIT cycles (mid-bit) and shifts it in LSB first, 8 samples total.
  - RX_STOP: samples rx_s after CLKS_PER_BIT cycles.
    - If 1: load byte_from_rx, pulse rx_byte_ready, move to RX_IDLE.
    - If 0: pulse rx_frame_err, leave byte_from_rx unchanged, move to RX_BREAK.
  - RX_BREAK: waits for rx_s = 1, then moves to RX_IDLE.
- TX and RX are fully independent. Simultaneous TX and RX activity is legal.
- Bit counters are $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1, and reload on every bit boundary. They never wrap mid-bit.

## Timing
- Reset values: tx = 1, tx_byte_ready = 1, byte_from_rx = 8'h00, rx_byte_ready = 0, new_rx_byte_indicate = 0, rx_frame_err = 0. All FSMs go to IDLE and counters to 0.
- Reset asserted mid-frame: tx goes to 1 immediately (asynchronous). The partial RX byte is discarded.
- TX request accepted at edge N:
  - tx_byte_ready = 0 and tx = 0 from edge N.
  - The start bit occupies cycles N … N+CLKS_PER_BIT-1.
  - tx_byte_ready returns to 1 at edge N + 10·CLKS_PER_BIT.
- Back-to-back TX: if tx_byte_start_n = 0 in the first cycle tx_byte_ready is high, the next start bit begins on the following edge.
- RX latency:
  - new_rx_byte_indicate fires 2 (synchroniser) + CLKS_PER_BIT/2 cycles after the rx falling edge (±1).
  - rx_byte_ready fires at the middle of the stop bit, 9·CLKS_PER_BIT cycles after the new_rx_byte_indicate pulse.
  - The RX FSM re-arms in RX_IDLE before the stop bit ends, so it tolerates up to ½ bit of baud mismatch.

## Structure
- A shared uart_defs package/header holds:
  - TX and RX state encodings (3-bit localparams).
  - DATA_BITS = 8.
  - The CLKS_PER_BIT derivation function.
- One sub-module: uart_rx_byte, containing the synchroniser, the RX FSM and the RX outputs. The TX FSM lives in the top level. Target about 250 lines total.

## Test plan
All scenarios run with CLK_FREQ = 1_600_000 and BAUD_RATE = 100_000, giving CLKS_PER_BIT = 16.
- Reset, then byte_for_tx = 8'hA5 with tx_byte_start_n low for 2 cycles.
  - Required: exactly one frame on tx, bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 cycles.
  - Required: tx_byte_ready low for 160 cycles.
- Loopback of tx to rx, sending 8'h3C then 8'hC3 back-to-back.
  - Required: two new_rx_byte_indicate pulses, two rx_byte_ready pulses.
  - Required: byte_from_rx = 8'h3C, then 8'hC3.
- rx low glitch of 5 cycles.
  - Required: no new_rx_byte_indicate, no rx_byte_ready, FSM back in RX_IDLE.
- Frame 8'h81 with the stop bit forced low, then rx returned high.
  - Required: one rx_frame_err pulse, no rx_byte_ready, byte_from_rx unchanged.
  - Required: the next good frame 8'h55 is received correctly.
- rst pulled low at the 4th data bit of a TX frame and of an RX frame.
  - Required: tx = 1 immediately, all outputs at reset values.
  - Required: the next frame after release works.
- Simultaneous TX 8'hFF and independent RX 8'h00, both started in the same cycle.
  - Required: both complete correctly, with no interaction between the two paths.

Source files
------------

// File: rtl/uart_byte_transceiver_pkg.sv
// Shared definitions for the byte-level 8N1 UART: state encodings, frame
// geometry and the bit-period derivation used by both directions.
package uart_byte_transceiver_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_byte_transceiver_rx.sv
// Receive half of the UART: two-flop synchroniser on rx, mid-bit sampling
// FSM and the registered byte/strobe outputs.
module uart_rx_byte
  import uart_byte_transceiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_from_rx,
  output logic       rx_byte_ready,
  output logic       new_rx_byte_indicate,
  output logic       rx_frame_err
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       byte_q, byte_d;
  logic             rdy_q, rdy_d;
  logic             ind_q, ind_d;
  logic             err_q, err_d;
  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;

  // Next-state and output logic for the receive FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    byte_d    = byte_q;
    rdy_d     = 1'b0;
    ind_d     = 1'b0;
    err_d     = 1'b0;
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;

    case (state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          state_d = RX_START;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = RX_IDLE;
        end
      end
      // Re-check half a bit in so short low glitches are rejected.
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = CNT_ZERO;
          if (!rx_s_q) begin
            ind_d   = 1'b1;
            idx_d   = 3'd0;
            state_d = RX_DATA;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_ZERO;
          shreg_d = {rx_s_q, shreg_q[7:1]};
          if (idx_q == LAST_BIT) begin
            state_d = RX_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // Returning to idle at mid stop bit gives half a bit of slack for baud skew.
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = CNT_ZERO;
          if (rx_s_q) begin
            byte_d  = shreg_q;
            rdy_d   = 1'b1;
            state_d = RX_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RX_BREAK: begin
        if (rx_s_q) begin
          state_d = RX_IDLE;
        end else begin
          state_d = RX_BREAK;
        end
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Receive state, synchroniser and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RX_IDLE;
      cnt_q     <= CNT_ZERO;
      idx_q     <= 3'd0;
      shreg_q   <= 8'h00;
      byte_q    <= 8'h00;
      rdy_q     <= 1'b0;
      ind_q     <= 1'b0;
      err_q     <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      byte_q    <= byte_d;
      rdy_q     <= rdy_d;
      ind_q     <= ind_d;
      err_q     <= err_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
    end
  end

  assign byte_from_rx         = byte_q;
  assign rx_byte_ready        = rdy_q;
  assign new_rx_byte_indicate = ind_q;
  assign rx_frame_err         = err_q;

endmodule

// File: rtl/uart_byte_transceiver.sv
// Byte-level 8N1 UART: transmit FSM lives here, receive path is delegated
// to uart_rx_byte. The two directions share nothing but clock and reset.
module uart_byte_transceiver
  import uart_byte_transceiver_pkg::*;
#(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_byte_start_n,
  input  logic [7:0] byte_for_tx,
  output logic       tx,
  output logic       tx_byte_ready,
  input  logic       rx,
  output logic [7:0] byte_from_rx,
  output logic       rx_byte_ready,
  output logic       new_rx_byte_indicate,
  output logic       rx_frame_err
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;

  // Next-state logic; tx and ready are computed one cycle ahead so they register cleanly
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    ready_d = ready_q;

    case (state_q)
      TX_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (!tx_byte_start_n) begin
          shreg_d = byte_for_tx;
          cnt_d   = CNT_ZERO;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          state_d = TX_START;
        end else begin
          state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_ZERO;
          idx_d   = 3'd0;
          tx_d    = shreg_q[0];
          state_d = TX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      TX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = CNT_ZERO;
          if (idx_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = TX_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shreg_q[idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      TX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = CNT_ZERO;
          tx_d    = 1'b1;
          ready_d = 1'b1;
          state_d = TX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        cnt_d   = CNT_ZERO;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        state_d = TX_IDLE;
      end
    endcase
  end

  // Transmit state and line registers; reset forces the line idle immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= CNT_ZERO;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
    end
  end

  assign tx            = tx_q;
  assign tx_byte_ready = ready_q;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk                  (clk),
    .rst                  (rst),
    .rx                   (rx),
    .byte_from_rx         (byte_from_rx),
    .rx_byte_ready        (rx_byte_ready),
    .new_rx_byte_indicate (new_rx_byte_indicate),
    .rx_frame_err         (rx_frame_err)
  );

endmodule

// File: tb/tb_uart_byte_transceiver.sv
// Self-checking bench for uart_byte_transceiver at 16 clocks per bit, with a
// frame-level reference model for both directions.
module tb_uart_byte_transceiver;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;
  localparam int C = 16;
  localparam int H = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_n = 1'b1;
  logic [7:0] byte_for_tx = 8'h00;
  logic       tx, tx_byte_ready;
  logic       rx_bench = 1'b1;
  logic       loopback = 1'b0;
  logic       rx_w;
  logic [7:0] byte_from_rx;
  logic       rx_byte_ready, new_rx_byte_indicate, rx_frame_err;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int n_rdy = 0, n_ind = 0, n_err = 0;
  int last_rdy = 0, last_ind = 0, fall_cyc = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_last = 8'h00;

  assign rx_w = loopback ? tx : rx_bench;

  always #5 clk = ~clk;

  uart_byte_transceiver #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .tx_byte_start_n      (start_n),
    .byte_for_tx          (byte_for_tx),
    .tx                   (tx),
    .tx_byte_ready        (tx_byte_ready),
    .rx                   (rx_w),
    .byte_from_rx         (byte_from_rx),
    .rx_byte_ready        (rx_byte_ready),
    .new_rx_byte_indicate (new_rx_byte_indicate),
    .rx_frame_err         (rx_frame_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record RX strobes away from the active edge
  always @(negedge clk) begin
    if (rx_byte_ready === 1'b1) begin
      got_q.push_back(byte_from_rx);
      n_rdy    <= n_rdy + 1;
      last_rdy <= cyc;
    end
    if (new_rx_byte_indicate === 1'b1) begin
      n_ind    <= n_ind + 1;
      last_ind <= cyc;
    end
    if (rx_frame_err === 1'b1) n_err <= n_err + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // Line level for bit slot i of a frame: start, 8 data LSB first, stop.
  function automatic logic frame_bit(input logic [7:0] d, input int i, input logic stop);
    if (i == 0) return 1'b0;
    else if (i == 9) return stop;
    else return d[i-1];
  endfunction

  // Called at a negedge; request a frame and check every cycle of it.
  task automatic send_tx(input logic [7:0] d, input int hold);
    int bad;
    int low_cnt;
    low_cnt     = 0;
    start_n     = 1'b0;
    byte_for_tx = d;
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int k = 0; k < C; k++) begin
        @(negedge clk);
        if (b == 0 && k == hold - 1) start_n = 1'b1;
        if (tx !== frame_bit(d, b, 1'b1)) bad++;
        if (tx_byte_ready === 1'b0) low_cnt++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL tx_bit[%0d] byte=%h: %0d of %0d cycles differ from level %b",
                 b, d, bad, C, frame_bit(d, b, 1'b1));
      end
    end
    @(negedge clk);
    checks++;
    if (tx_byte_ready !== 1'b1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL tx_ready_return: ready=%b tx=%b, required 1 1", tx_byte_ready, tx);
    end
    checks++;
    if (low_cnt != 10 * C) begin
      errors++;
      $display("FAIL tx_ready_low: low for %0d cycles, required %0d", low_cnt, 10 * C);
    end
  endtask

  // Drive one frame onto rx, bit by bit; stop selects the stop-bit level.
  task automatic send_rx(input logic [7:0] d, input logic stop);
    for (int i = 0; i < 10; i++) begin
      rx_bench = frame_bit(d, i, stop);
      if (i == 0) fall_cyc = cyc + 1;
      repeat (C) @(negedge clk);
    end
    rx_bench = 1'b1;
    if (stop) exp_last = d;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || tx_byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tx: tx=%b ready=%b, required 1 1", tx, tx_byte_ready);
    end
    checks++;
    if (byte_from_rx !== 8'h00 || rx_byte_ready !== 1'b0 ||
        new_rx_byte_indicate !== 1'b0 || rx_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rx: byte=%h rdy=%b ind=%b err=%b, required 00 0 0 0",
               byte_from_rx, rx_byte_ready, new_rx_byte_indicate, rx_frame_err);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tx_single();
    int bad;
    bad = 0;
    send_tx(8'hA5, 2);
    for (int k = 0; k < 3 * C; k++) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_byte_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL tx_single_frame: %0d idle cycles not high after frame, required 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int n0, i0, r0;
    logic [7:0] g0, g1;
    n0 = got_q.size(); i0 = n_ind; r0 = n_rdy;
    loopback = 1'b1;
    send_tx(8'h3C, 2);
    send_tx(8'hC3, 2);
    repeat (4) @(negedge clk);
    loopback = 1'b0;
    exp_last = 8'hC3;
    checks++;
    if (n_ind - i0 != 2 || n_rdy - r0 != 2) begin
      errors++;
      $display("FAIL b2b_pulses: ind=%0d rdy=%0d, required 2 2", n_ind - i0, n_rdy - r0);
    end
    g0 = (got_q.size() > n0) ? got_q[n0] : 8'hxx;
    g1 = (got_q.size() > n0 + 1) ? got_q[n0+1] : 8'hxx;
    checks++;
    if (g0 !== 8'h3C || g1 !== 8'hC3) begin
      errors++;
      $display("FAIL b2b_bytes: got %h %h, required 3c c3", g0, g1);
    end
    checks++;
    if (last_rdy - last_ind != 9 * C) begin
      errors++;
      $display("FAIL rx_ready_latency: %0d cycles, required %0d", last_rdy - last_ind, 9 * C);
    end
  endtask

  task automatic test_glitch();
    int i0, r0, n0;
    logic [7:0] d, g;
    i0 = n_ind; r0 = n_rdy;
    rx_bench = 1'b0;
    repeat (5) @(negedge clk);
    rx_bench = 1'b1;
    repeat (2 * C) @(negedge clk);
    checks++;
    if (n_ind != i0 || n_rdy != r0) begin
      errors++;
      $display("FAIL glitch_pulses: ind=%0d rdy=%0d, required 0 0", n_ind - i0, n_rdy - r0);
    end
    d  = 8'($urandom);
    n0 = got_q.size();
    send_rx(d, 1'b1);
    repeat (4) @(negedge clk);
    g = (got_q.size() > n0) ? got_q[n0] : 8'hxx;
    checks++;
    if (got_q.size() != n0 + 1 || g !== d) begin
      errors++;
      $display("FAIL glitch_next_frame: %0d bytes, first %h, required 1 byte %h",
               got_q.size() - n0, g, d);
    end
    checks++;
    if (last_ind - fall_cyc < 2 + H - 1 || last_ind - fall_cyc > 2 + H + 1) begin
      errors++;
      $display("FAIL rx_start_latency: %0d cycles, required %0d +-1", last_ind - fall_cyc, 2 + H);
    end
  endtask

  task automatic test_frame_err();
    int e0, r0;
    e0 = n_err; r0 = n_rdy;
    send_rx(8'h81, 1'b0);
    repeat (C) @(negedge clk);
    checks++;
    if (n_err - e0 != 1 || n_rdy != r0) begin
      errors++;
      $display("FAIL frame_err_pulses: err=%0d rdy=%0d, required 1 0", n_err - e0, n_rdy - r0);
    end
    checks++;
    if (byte_from_rx !== exp_last) begin
      errors++;
      $display("FAIL frame_err_hold: byte=%h, required %h", byte_from_rx, exp_last);
    end
    send_rx(8'h55, 1'b1);
    repeat (4) @(negedge clk);
    checks++;
    if (byte_from_rx !== 8'h55 || n_rdy - r0 != 1) begin
      errors++;
      $display("FAIL frame_err_recover: byte=%h rdy=%0d, required 55 1", byte_from_rx, n_rdy - r0);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    start_n     = 1'b0;
    byte_for_tx = 8'h96;
    for (int k = 0; k < 4 * C + H; k++) begin
      rx_bench = frame_bit(8'hE7, k / C, 1'b1);
      @(negedge clk);
      if (k == 0) start_n = 1'b1;
    end
    checks++;
    if (tx !== frame_bit(8'h96, 4, 1'b1)) begin
      errors++;
      $display("FAIL rst_pre_tx: tx=%b, required %b", tx, frame_bit(8'h96, 4, 1'b1));
    end
    rst = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || tx_byte_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_tx: tx=%b ready=%b, required 1 1", tx, tx_byte_ready);
    end
    checks++;
    if (byte_from_rx !== 8'h00 || rx_byte_ready !== 1'b0 ||
        new_rx_byte_indicate !== 1'b0 || rx_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_rx: byte=%h rdy=%b ind=%b err=%b, required 00 0 0 0",
               byte_from_rx, rx_byte_ready, new_rx_byte_indicate, rx_frame_err);
    end
    exp_last = 8'h00;
    rx_bench = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    r0 = n_rdy;
    repeat (2 * C) @(negedge clk);
    checks++;
    if (n_rdy != r0 || byte_from_rx !== 8'h00) begin
      errors++;
      $display("FAIL rst_discard: rdy=%0d byte=%h, required 0 00", n_rdy - r0, byte_from_rx);
    end
    fork
      send_tx(8'h69, 2);
      send_rx(8'h3A, 1'b1);
    join
    repeat (4) @(negedge clk);
    checks++;
    if (byte_from_rx !== 8'h3A || n_rdy - r0 != 1) begin
      errors++;
      $display("FAIL rst_next_frame: byte=%h rdy=%0d, required 3a 1", byte_from_rx, n_rdy - r0);
    end
  endtask

  task automatic test_simultaneous();
    int r0, e0;
    r0 = n_rdy; e0 = n_err;
    fork
      send_tx(8'hFF, 2);
      send_rx(8'h00, 1'b1);
    join
    repeat (4) @(negedge clk);
    checks++;
    if (byte_from_rx !== 8'h00 || n_rdy - r0 != 1 || n_err != e0) begin
      errors++;
      $display("FAIL simultaneous_rx: byte=%h rdy=%0d err=%0d, required 00 1 0",
               byte_from_rx, n_rdy - r0, n_err - e0);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] d, g;
    logic       stop;
    int n0, e0, exp_err, bad;
    n0 = got_q.size(); e0 = n_err; exp_err = 0; bad = 0;
    for (int t = 0; t < 8; t++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        loopback = 1'b1;
        send_tx(d, $urandom_range(1, 2));
        repeat (2) @(negedge clk);
        loopback = 1'b0;
        exp_q.push_back(d);
        exp_last = d;
      end else begin
        stop = ($urandom_range(0, 3) != 0);
        send_rx(d, stop);
        if (stop) exp_q.push_back(d);
        else exp_err++;
      end
      repeat ($urandom_range(C, 3 * C)) @(negedge clk);
    end
    checks++;
    if (got_q.size() - n0 != exp_q.size() || n_err - e0 != exp_err) begin
      errors++;
      $display("FAIL random_counts: bytes=%0d errs=%0d, required %0d %0d",
               got_q.size() - n0, n_err - e0, exp_q.size(), exp_err);
    end
    foreach (exp_q[i]) begin
      g = (got_q.size() > n0 + i) ? got_q[n0+i] : 8'hxx;
      if (g !== exp_q[i]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_bytes: %0d of %0d bytes differ from model", bad, exp_q.size());
    end
    checks++;
    if (byte_from_rx !== exp_last) begin
      errors++;
      $display("FAIL random_last: byte=%h, required %h", byte_from_rx, exp_last);
    end
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
